// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: drives oen/cp of a 74xx374 bank for one src->dst bus copy.
// In: cp, mrn, req, src, dst.  Out: busy, done, err, oen_o (act-low), ld_o.
module bus_xfer_seq #(
  parameter int NREG   = 8,
  parameter int SETTLE = 1,
  parameter int HOLD   = 1,
  parameter int IW     = $clog2(NREG)
) (
  input  logic            cp,
  input  logic            mrn,
  input  logic            req,
  input  logic [IW-1:0]   src,
  input  logic [IW-1:0]   dst,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [NREG-1:0] oen_o,
  output logic [NREG-1:0] ld_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_LATCH,
    S_TAIL,
    S_DONE
  } state_e;

  localparam logic [3:0] SET_M1 = 4'(SETTLE - 1);
  localparam logic [3:0] HLD_M1 = 4'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [IW:0] NREG_W = (IW+1)'(NREG);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [IW-1:0]   src_q;
  logic [IW-1:0]   dst_q;
  logic [NREG-1:0] oen_q;
  logic [NREG-1:0] ld_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            acc_ok;

  function automatic logic [NREG-1:0] dec(
    input logic [IW-1:0] i
  );
    logic [NREG-1:0] m;
    for (int k = 0; k < NREG; k++) begin
      m[k] = (i == IW'(k));
    end
    return m;
  endfunction

  // Non-power-of-two banks leave index codes with no register behind them.
  assign acc_ok = (src != dst)
               && ({1'b0, src} < NREG_W)
               && ({1'b0, dst} < NREG_W);

  always_ff @(posedge cp or negedge mrn) begin
    if (!mrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      oen_q   <= '1;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ld_q   <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if (acc_ok) begin
              src_q   <= src;
              dst_q   <= dst;
              oen_q   <= ~dec(src);
              busy_q  <= 1'b1;
              cnt_q   <= SET_M1;
              state_q <= S_DRIVE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (cnt_q == 4'd0) begin
            ld_q    <= dec(dst_q);
            state_q <= S_LATCH;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_LATCH: begin
          if (HOLD > 0) begin
            cnt_q   <= HLD_M1;
            state_q <= S_TAIL;
          end else begin
            oen_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_TAIL: begin
          if (cnt_q == 4'd0) begin
            oen_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          oen_q   <= '1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign oen_o = oen_q;
  assign ld_o  = ld_q;

endmodule
